// File: rtl/regbank_arbiter.sv
// Two-requester round-robin arbiter in front of an 8-entry register bank.
// Each access takes one IDLE cycle to arbitrate and one ACCESS cycle to complete.
module regbank_arbiter #(
   parameter int WIDTH = 16,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_i,
   input  logic             req1_i,
   input  logic             we0_i,
   input  logic             we1_i,
   input  logic [AW-1:0]    addr0_i,
   input  logic [AW-1:0]    addr1_i,
   input  logic [WIDTH-1:0] wdata0_i,
   input  logic [WIDTH-1:0] wdata1_i,
   output logic             gnt0_o,
   output logic             gnt1_o,
   output logic             rvalid0_o,
   output logic             rvalid1_o,
   output logic [WIDTH-1:0] rdata0_o,
   output logic [WIDTH-1:0] rdata1_o,
   output logic             busy_o
);

   localparam int DEPTH = 2 ** AW;

   typedef enum logic {
      IDLE,
      ACCESS
   } state_e;

   state_e             state_q, state_d;
   logic               win_q, win_d;
   logic               lastGnt_q, lastGnt_d;
   logic               we_q, we_d;
   logic [AW-1:0]      addr_q, addr_d;
   logic [WIDTH-1:0]   wdata_q, wdata_d;
   logic [WIDTH-1:0]   rdata_q, rdata_d;
   logic [DEPTH-1:0]   loadEn;
   logic [WIDTH-1:0]   bank_q [DEPTH];

   // On a tie the requester not granted last time wins; a lone requester always wins.
   always_comb begin
      state_d   = state_q;
      win_d     = win_q;
      lastGnt_d = lastGnt_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      unique case (state_q)
         IDLE: begin
            if (req0_i || req1_i) begin
               win_d   = (req0_i && req1_i) ? ~lastGnt_q : req1_i;
               we_d    = win_d ? we1_i : we0_i;
               addr_d  = win_d ? addr1_i : addr0_i;
               wdata_d = win_d ? wdata1_i : wdata0_i;
               rdata_d = bank_q[addr_d];
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            lastGnt_d = win_q;
            state_d   = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         win_q     <= 1'b0;
         lastGnt_q <= 1'b1;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         win_q     <= win_d;
         lastGnt_q <= lastGnt_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
      end
   end

   // The only write path into the bank: one entry loads at the edge ending a write ACCESS.
   always_comb begin
      loadEn = '0;
      if (state_q == ACCESS && we_q) begin
         loadEn[addr_q] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            bank_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            if (loadEn[k]) begin
               bank_q[k] <= wdata_q;
            end
         end
      end
   end

   assign busy_o    = (state_q == ACCESS);
   assign gnt0_o    = busy_o && !win_q;
   assign gnt1_o    = busy_o && win_q;
   assign rvalid0_o = gnt0_o && !we_q;
   assign rvalid1_o = gnt1_o && !we_q;
   assign rdata0_o  = rvalid0_o ? rdata_q : '0;
   assign rdata1_o  = rvalid1_o ? rdata_q : '0;

endmodule

// File: tb/tb_regbank_arbiter.sv
// Directed bench for regbank_arbiter: one task per scenario, inputs and samples on the falling edge.
module tb_regbank_arbiter;

   logic        clk;
   logic        rst_n;
   logic        req0, req1, we0, we1;
   logic [2:0]  addr0, addr1;
   logic [15:0] wdata0, wdata1;
   logic        gnt0, gnt1, rvalid0, rvalid1, busy;
   logic [15:0] rdata0, rdata1;

   int total = 0;
   int bad   = 0;

   regbank_arbiter #(.WIDTH(16), .AW(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req0_i    (req0),
      .req1_i    (req1),
      .we0_i     (we0),
      .we1_i     (we1),
      .addr0_i   (addr0),
      .addr1_i   (addr1),
      .wdata0_i  (wdata0),
      .wdata1_i  (wdata1),
      .gnt0_o    (gnt0),
      .gnt1_o    (gnt1),
      .rvalid0_o (rvalid0),
      .rvalid1_o (rvalid1),
      .rdata0_o  (rdata0),
      .rdata1_o  (rdata1),
      .busy_o    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issues one request from a falling edge and waits (bounded) for its grant; waitCyc = -1 on timeout.
   task automatic runReq(input int port, input logic we, input logic [2:0] addr,
                         input logic [15:0] wd, input bit hold,
                         output int waitCyc, output logic rv, output logic [15:0] rd,
                         output logic oGnt, output logic [15:0] oRd);
      logic g;
      if (port == 0) begin
         req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd;
      end else begin
         req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd;
      end
      waitCyc = -1; rv = 1'b0; rd = '0; oGnt = 1'b0; oRd = '0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         g = (port == 0) ? gnt0 : gnt1;
         if (g === 1'b1) begin
            waitCyc = c;
            rv   = (port == 0) ? rvalid0 : rvalid1;
            rd   = (port == 0) ? rdata0 : rdata1;
            oGnt = (port == 0) ? gnt1 : gnt0;
            oRd  = (port == 0) ? rdata1 : rdata0;
            break;
         end
      end
      if (!hold) begin
         if (port == 0) req0 = 1'b0;
         else           req1 = 1'b0;
      end
   endtask

   task automatic test_reset();
      int w; logic rv, og; logic [15:0] rd, ord;
      rst_n = 1'b0;
      req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
      repeat (2) @(negedge clk);
      total++;
      if ({gnt0, gnt1, rvalid0, rvalid1, busy} !== 5'b0) begin
         bad++; $display("[TB] FAIL reset_ctrl: got %b expected 00000", {gnt0, gnt1, rvalid0, rvalid1, busy});
      end
      total++;
      if ({rdata0, rdata1} !== 32'h0) begin
         bad++; $display("[TB] FAIL reset_rdata: got %h expected 00000000", {rdata0, rdata1});
      end
      rst_n = 1'b1;
      runReq(0, 1'b1, 3'd3, 16'hAAAA, 1'b0, w, rv, rd, og, ord);
      total++;
      if (w !== 1) begin
         bad++; $display("[TB] FAIL reset_wr_latency: got %0d expected 1", w);
      end
      @(negedge clk);
      runReq(0, 1'b0, 3'd3, 16'h0, 1'b1, w, rv, rd, og, ord);
      total++;
      if ({busy, rv, rd} !== {1'b1, 1'b1, 16'hAAAA}) begin
         bad++; $display("[TB] FAIL pre_reset_read: got %b/%b/%h expected 1/1/aaaa", busy, rv, rd);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({gnt0, rvalid0, busy, rdata0} !== 19'h0) begin
         bad++; $display("[TB] FAIL midrun_reset: got %b/%b/%b/%h expected 0/0/0/0000", gnt0, rvalid0, busy, rdata0);
      end
      req0 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         runReq(0, 1'b0, k[2:0], 16'h0, 1'b0, w, rv, rd, og, ord);
         total++;
         if (w !== 1 || rv !== 1'b1 || rd !== 16'h0000) begin
            bad++; $display("[TB] FAIL cleared_entry%0d: got wait=%0d rv=%b rd=%h expected 1/1/0000", k, w, rv, rd);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_write_read();
      int w; logic rv, og; logic [15:0] rd, ord;
      runReq(0, 1'b1, 3'd5, 16'hBEEF, 1'b0, w, rv, rd, og, ord);
      total++;
      if (w !== 1 || rv !== 1'b0 || rd !== 16'h0) begin
         bad++; $display("[TB] FAIL write_beef: got wait=%0d rv=%b rd=%h expected 1/0/0000", w, rv, rd);
      end
      @(negedge clk);
      runReq(1, 1'b0, 3'd5, 16'h0, 1'b0, w, rv, rd, og, ord);
      total++;
      if (w !== 1 || rv !== 1'b1 || rd !== 16'hBEEF) begin
         bad++; $display("[TB] FAIL read_beef_p1: got wait=%0d rv=%b rd=%h expected 1/1/beef", w, rv, rd);
      end
      total++;
      if (og !== 1'b0 || ord !== 16'h0) begin
         bad++; $display("[TB] FAIL other_port_quiet: got gnt0=%b rdata0=%h expected 0/0000", og, ord);
      end
      @(negedge clk);
   endtask

   task automatic test_round_robin();
      logic [2:0] exp;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 3'd0; addr1 = 3'd1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c % 2 == 0)      exp = 3'b000;
         else if (c % 4 == 1) exp = 3'b110;
         else                 exp = 3'b101;
         total++;
         if ({busy, gnt0, gnt1} !== exp) begin
            bad++; $display("[TB] FAIL rr_cycle%0d: got busy/gnt0/gnt1=%b expected %b", c, {busy, gnt0, gnt1}, exp);
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int w; logic rv, og; logic [15:0] rd, ord;
      runReq(0, 1'b1, 3'd2, 16'h1234, 1'b1, w, rv, rd, og, ord);
      total++;
      if (w !== 1) begin
         bad++; $display("[TB] FAIL b2b_first: got wait=%0d expected 1", w);
      end
      runReq(0, 1'b0, 3'd2, 16'h0, 1'b0, w, rv, rd, og, ord);
      total++;
      if (w !== 2 || rv !== 1'b1 || rd !== 16'h1234) begin
         bad++; $display("[TB] FAIL b2b_second: got wait=%0d rv=%b rd=%h expected 2/1/1234", w, rv, rd);
      end
   endtask

   task automatic test_reset_during_write();
      int w; logic rv, og; logic [15:0] rd, ord;
      @(negedge clk);
      runReq(1, 1'b1, 3'd7, 16'hFFFF, 1'b1, w, rv, rd, og, ord);
      total++;
      if (w !== 1 || busy !== 1'b1) begin
         bad++; $display("[TB] FAIL rdw_grant: got wait=%0d busy=%b expected 1/1", w, busy);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({gnt1, busy, rvalid1} !== 3'b000) begin
         bad++; $display("[TB] FAIL rdw_clear: got gnt1/busy/rvalid1=%b expected 000", {gnt1, busy, rvalid1});
      end
      req1 = 1'b0; we1 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      req0 = 1'b1; we0 = 1'b0; addr0 = 3'd7;
      req1 = 1'b1; we1 = 1'b0; addr1 = 3'd5;
      @(negedge clk);
      total++;
      if ({gnt0, gnt1, rvalid0, rdata0} !== {3'b101, 16'h0000}) begin
         bad++; $display("[TB] FAIL rdw_tie_p0: got %b/%h expected 101/0000", {gnt0, gnt1, rvalid0}, rdata0);
      end
      req0 = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({gnt0, gnt1, rvalid1, rdata1} !== {3'b011, 16'h0000}) begin
         bad++; $display("[TB] FAIL rdw_p1_cleared: got %b/%h expected 011/0000", {gnt0, gnt1, rvalid1}, rdata1);
      end
      req1 = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_stability();
      int w; logic rv, og; logic [15:0] rd, ord;
      runReq(1, 1'b1, 3'd1, 16'h5A5A, 1'b1, w, rv, rd, og, ord);
      total++;
      if (w !== 1) begin
         bad++; $display("[TB] FAIL stab_grant: got wait=%0d expected 1", w);
      end
      addr1 = 3'd6; wdata1 = 16'h1111; req1 = 1'b0;
      @(negedge clk);
      runReq(0, 1'b0, 3'd1, 16'h0, 1'b0, w, rv, rd, og, ord);
      total++;
      if (w !== 1 || rv !== 1'b1 || rd !== 16'h5A5A) begin
         bad++; $display("[TB] FAIL stab_addr1: got wait=%0d rv=%b rd=%h expected 1/1/5a5a", w, rv, rd);
      end
      @(negedge clk);
      runReq(0, 1'b0, 3'd6, 16'h0, 1'b0, w, rv, rd, og, ord);
      total++;
      if (w !== 1 || rd !== 16'h0000) begin
         bad++; $display("[TB] FAIL stab_addr6: got wait=%0d rd=%h expected 1/0000", w, rd);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_round_robin();
      test_back_to_back();
      test_reset_during_write();
      test_stability();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
